// File: rtl/radix4_seq_multiplier_pkg.sv
// Shared constants and state encoding for the radix-4 sequential multiplier.
package radix4_seq_multiplier_pkg;

    localparam int unsigned DIGIT_W = 2;
    localparam int unsigned DPROD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/digit_mul2x2.sv
// Combinational 2x2 unsigned multiplier: AND partial products folded by two half adders.
module digit_mul2x2
    import radix4_seq_multiplier_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    output logic [DPROD_W-1:0] o_p
);

    logic w_pp00;
    logic w_pp01;
    logic w_pp10;
    logic w_pp11;
    logic w_s1;
    logic w_c1;
    logic w_s2;
    logic w_c2;

    assign w_pp00 = i_a[0] & i_b[0];
    assign w_pp01 = i_a[1] & i_b[0];
    assign w_pp10 = i_a[0] & i_b[1];
    assign w_pp11 = i_a[1] & i_b[1];

    // Weight-2 column, then its carry joins the weight-4 partial product.
    assign w_s1 = w_pp01 ^ w_pp10;
    assign w_c1 = w_pp01 & w_pp10;
    assign w_s2 = w_pp11 ^ w_c1;
    assign w_c2 = w_pp11 & w_c1;

    assign o_p = {w_c2, w_s2, w_s1, w_pp00};

endmodule

// File: rtl/radix4_seq_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier that accumulates one 2x2 digit product per cycle,
// with valid/ready handshakes on the operand and result sides.
module radix4_seq_multiplier
    import radix4_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned D     = WIDTH / 2;
    localparam int unsigned CNT_W = (D > 1) ? $clog2(D) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_i;
    logic [CNT_W-1:0]   r_j;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT_W-1:0] w_a_dig;
    logic [DIGIT_W-1:0] w_b_dig;
    logic [DPROD_W-1:0] w_dprod;
    logic [CNT_W+1:0]   w_shamt;
    logic [2*WIDTH-1:0] w_term;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_i == LAST) && (r_j == LAST);

    assign w_a_dig = DIGIT_W'(r_a >> {r_i, 1'b0});
    assign w_b_dig = DIGIT_W'(r_b >> {r_j, 1'b0});

    digit_mul2x2 u_digit_mul (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_dprod)
    );

    // Digit weights are 4^(i+j), i.e. a left shift by 2*(i+j).
    assign w_shamt = {({1'b0, r_i} + {1'b0, r_j}), 1'b0};
    assign w_term  = (2*WIDTH)'(w_dprod) << w_shamt;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_i   <= '0;
                r_j   <= '0;
                r_acc <= '0;
            end else if (r_state == BUSY) begin
                r_acc <= r_acc + w_term;
                if (r_j == LAST) begin
                    r_j <= '0;
                    r_i <= r_i + CNT_W'(1);
                end else begin
                    r_j <= r_j + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign p         = r_acc;

endmodule

// File: tb/tb_radix4_seq_multiplier.sv
// Self-checking bench: vector table, randomized ops against a plain a*b model,
// hand-written corner sequences, and an exhaustive WIDTH=2 instance.
module tb_radix4_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;

    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic        out_valid2;
    logic        out_ready2;
    logic [3:0]  p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    radix4_seq_multiplier #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .p         (p2)
    );

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        int          hold;
        logic [15:0] exp_p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One WIDTH=8 transaction; holds out_ready low for 'hold' DONE cycles.
    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_v, input int hold,
                          output logic [15:0] pr, output int lat);
        int n;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 1);
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'hFF;
        b        = 8'hFF;
        chk("in_ready_after_accept", 32'(in_ready), 0);
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        pr  = p;
        for (int k = 0; k < hold; k++) begin
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_p", 32'(p), 32'(pr));
            chk("hold_in_ready", 32'(in_ready), 0);
            in_valid = k[0];
            a        = 8'hFF;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_xfer_in_ready", 32'(in_ready), 1);
        chk("post_xfer_out_valid", 32'(out_valid), 0);
    endtask

    task automatic do_op2(input logic [1:0] ta, input logic [1:0] tb_v,
                          output logic [3:0] pr, output int lat);
        int n;
        @(negedge clk);
        a2         = ta;
        b2         = tb_v;
        in_valid2  = 1'b1;
        out_ready2 = 1'b0;
        @(negedge clk);
        in_valid2 = 1'b0;
        n = 1;
        while (!out_valid2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat        = n;
        pr         = p2;
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    initial begin
        vec_t        vecs[4];
        logic [15:0] pr;
        logic [3:0]  pr2;
        logic [15:0] exp;
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          lat;
        int          cyc;
        int          na;
        int          acc_t[2];
        logic [15:0] res[$];

        vecs[0] = '{8'hFF, 8'hFF, 0, 16'hFE01};
        vecs[1] = '{8'h0D, 8'h0B, 0, 16'h008F};
        vecs[2] = '{8'h00, 8'hA5, 0, 16'h0000};
        vecs[3] = '{8'h12, 8'h34, 5, 16'h03A8};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        a2         = '0;
        b2         = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_p", 32'(p), 0);
        chk("reset2_in_ready", 32'(in_ready2), 1);
        chk("reset2_p", 32'(p2), 0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            do_op8(vecs[v].va, vecs[v].vb, vecs[v].hold, pr, lat);
            chk("vec_p", 32'(pr), 32'(vecs[v].exp_p));
            chk("vec_latency", 32'(lat), 17);
        end

        // Reset at busy cycle 7 discards the operation.
        @(negedge clk);
        a        = 8'h80;
        b        = 8'h80;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_p", 32'(p), 0);
        do_op8(8'h03, 8'h05, 0, pr, lat);
        chk("after_rst_p", 32'(pr), 32'h000F);
        chk("after_rst_latency", 32'(lat), 17);

        // Back-to-back with out_ready tied high.
        @(negedge clk);
        out_ready = 1'b1;
        a         = 8'h10;
        b         = 8'h10;
        in_valid  = 1'b1;
        cyc       = 0;
        na        = 0;
        acc_t[0]  = 0;
        acc_t[1]  = 0;
        while ((na < 2 || res.size() < 2) && cyc < 200) begin
            if (in_valid && in_ready) begin
                acc_t[na] = cyc;
                na++;
            end
            if (out_valid) res.push_back(p);
            @(negedge clk);
            cyc++;
            if (na == 1) begin
                a = 8'hFE;
                b = 8'h02;
            end
            if (na == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("b2b_accepts", 32'(na), 2);
        chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 18);
        chk("b2b_results", 32'(res.size()), 2);
        if (res.size() == 2) begin
            chk("b2b_p0", 32'(res[0]), 32'h0100);
            chk("b2b_p1", 32'(res[1]), 32'h01FC);
        end

        // Randomized operands against a plain product model.
        for (int r = 0; r < 30; r++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            exp = 16'(ra) * 16'(rb);
            do_op8(ra, rb, int'($urandom_range(0, 2)), pr, lat);
            chk("rand_p", 32'(pr), 32'(exp));
            chk("rand_latency", 32'(lat), 17);
        end

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                do_op2(2'(i), 2'(j), pr2, lat);
                chk("w2_p", 32'(pr2), 32'(i * j));
                chk("w2_latency", 32'(lat), 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
